// File: rtl/thermal_channel_receiver_pkg.sv
// Shared types and constants for the thermal covert-channel receiver.
// Latency: n/a (definitions only); no flow control involved.
package thermal_channel_receiver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } frame_state_t;

   localparam int FRAME_BITS            = 8;
   localparam int DEFAULT_WINDOW_CYCLES = 1000000;
   localparam int DEFAULT_CNT_W         = 20;
   localparam int DEFAULT_BIT_WINDOWS   = 3;

endpackage

// File: rtl/thermal_channel_receiver_if.sv
// Control inputs and decoded outputs of the thermal channel receiver.
// Latency: n/a (wiring only); outputs are pulses with no backpressure.
interface thermal_channel_receiver_if #(
   parameter int CNT_W = thermal_channel_receiver_pkg::DEFAULT_CNT_W
);
   logic             enable;
   logic             ro_in;
   logic [CNT_W-1:0] thresh;
   logic [CNT_W-1:0] sample_count;
   logic             bit_valid;
   logic             bit_data;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             frame_err;
   logic [3:0]       leds;

   modport master (
      output enable, ro_in, thresh,
      input  sample_count, bit_valid, bit_data, byte_valid, byte_data, frame_err, leds
   );

   modport slave (
      input  enable, ro_in, thresh,
      output sample_count, bit_valid, bit_data, byte_valid, byte_data, frame_err, leds
   );
endinterface

// File: rtl/thermal_channel_receiver_ro_edge_counter.sv
// Synchronises the ring-oscillator, counts its rising edges per window and latches the total.
// Latency: edge counted 3 clk after it appears, count visible the cycle after window close; no backpressure.
module ro_edge_counter #(
   parameter int WINDOW_CYCLES = thermal_channel_receiver_pkg::DEFAULT_WINDOW_CYCLES,
   parameter int CNT_W         = thermal_channel_receiver_pkg::DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             ro_in,
   output logic             window_last,
   output logic [CNT_W-1:0] count_next,
   output logic [CNT_W-1:0] sample_count
);
   localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             sync_3;
   logic             rise;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] edge_cnt;

   // sync_1/sync_2 resolve metastability; sync_3 only delays for edge detect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_3 <= 1'b0;
      end else begin
         sync_1 <= ro_in;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
      end
   end

   assign rise        = sync_2 & ~sync_3;
   assign window_last = enable && (win_cnt == WIN_LAST);
   assign count_next  = (rise && (edge_cnt != {CNT_W{1'b1}})) ? edge_cnt + CNT_W'(1) : edge_cnt;

   // count_next already holds an edge arriving on the last cycle, so restarting at 0 drops nothing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt      <= '0;
         edge_cnt     <= '0;
         sample_count <= '0;
      end else if (!enable) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else if (window_last) begin
         win_cnt      <= '0;
         edge_cnt     <= '0;
         sample_count <= count_next;
      end else begin
         win_cnt  <= win_cnt + WIN_W'(1);
         edge_cnt <= count_next;
      end
   end

endmodule

// File: rtl/thermal_channel_receiver.sv
// Decodes a thermally modulated UART-like frame from ring-oscillator edge counts by window voting.
// Latency: bit_valid one cycle after the final window closes, byte_valid/frame_err with the stop bit; no backpressure.
module thermal_channel_receiver
   import thermal_channel_receiver_pkg::*;
#(
   parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
   parameter int BIT_WINDOWS   = DEFAULT_BIT_WINDOWS,
   parameter int CNT_W         = DEFAULT_CNT_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   thermal_channel_receiver_if.slave bus
);
   localparam int IDX_W = $clog2(FRAME_BITS);

   logic                  window_last;
   logic [CNT_W-1:0]      count_next;
   logic [CNT_W-1:0]      sample_count;
   logic                  hot;
   logic                  bit_fire;
   logic                  dec_bit;
   logic [3:0]            win_idx;
   logic [3:0]            votes;
   logic [3:0]            votes_total;
   logic                  bit_valid_q;
   logic                  bit_data_q;
   frame_state_t          state_q;
   frame_state_t          state_d;
   logic [FRAME_BITS-1:0] shreg_q;
   logic [FRAME_BITS-1:0] shreg_d;
   logic [IDX_W-1:0]      bit_idx_q;
   logic [IDX_W-1:0]      bit_idx_d;
   logic                  byte_fire;
   logic                  err_fire;
   logic                  byte_valid_q;
   logic                  frame_err_q;
   logic [7:0]            byte_data_q;

   ro_edge_counter #(
      .WINDOW_CYCLES (WINDOW_CYCLES),
      .CNT_W         (CNT_W)
   ) u_edge (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (bus.enable),
      .ro_in        (bus.ro_in),
      .window_last  (window_last),
      .count_next   (count_next),
      .sample_count (sample_count)
   );

   // Heating slows the oscillator, so fewer edges than the threshold means hot.
   assign hot         = count_next < bus.thresh;
   assign votes_total = votes + {3'b000, hot};
   assign dec_bit     = votes_total > 4'(BIT_WINDOWS / 2);
   assign bit_fire    = window_last && (win_idx == 4'(BIT_WINDOWS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_idx     <= '0;
         votes       <= '0;
         bit_valid_q <= 1'b0;
         bit_data_q  <= 1'b0;
      end else begin
         bit_valid_q <= bit_fire;
         if (!bus.enable) begin
            win_idx <= '0;
            votes   <= '0;
         end else if (bit_fire) begin
            win_idx    <= '0;
            votes      <= '0;
            bit_data_q <= dec_bit;
         end else if (window_last) begin
            win_idx <= win_idx + 4'd1;
            votes   <= votes_total;
         end
      end
   end

   // The frame FSM acts on the decoded bit as it is registered, so frame pulses line up with bit_valid.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      byte_fire = 1'b0;
      err_fire  = 1'b0;
      if (!bus.enable) begin
         state_d   = IDLE;
         bit_idx_d = '0;
      end else if (bit_fire) begin
         case (state_q)
            IDLE: begin
               bit_idx_d = '0;
               if (dec_bit) state_d = DATA;
            end
            DATA: begin
               shreg_d = {dec_bit, shreg_q[FRAME_BITS-1:1]};
               if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
                  bit_idx_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
            STOP: begin
               if (dec_bit) err_fire  = 1'b1;
               else         byte_fire = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_idx_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         byte_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_idx_q    <= bit_idx_d;
         byte_valid_q <= byte_fire;
         frame_err_q  <= err_fire;
         if (byte_fire) byte_data_q <= shreg_q;
      end
   end

   assign bus.sample_count = sample_count;
   assign bus.bit_valid    = bit_valid_q;
   assign bus.bit_data     = bit_data_q;
   assign bus.byte_valid   = byte_valid_q;
   assign bus.byte_data    = byte_data_q;
   assign bus.frame_err    = frame_err_q;
   assign bus.leds         = byte_data_q[3:0];

endmodule

// File: tb/tb_thermal_channel_receiver.sv
// Directed bench: drives window-aligned hot/cold oscillator patterns and checks decoded frames.
`timescale 1ns/1ps
module tb_thermal_channel_receiver;
   import thermal_channel_receiver_pkg::*;

   localparam int WC = 16;
   localparam int BW = 3;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   thermal_channel_receiver_if #(.CNT_W(CW)) bus ();

   thermal_channel_receiver #(
      .WINDOW_CYCLES (WC),
      .BIT_WINDOWS   (BW),
      .CNT_W         (CW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int          checks = 0;
   int          failures = 0;
   bit          mode [0:63];
   int          nbit, nbyte, nerr, nonco, npulse, nbad;
   logic [31:0] bits_seen;
   logic [7:0]  last_byte;
   int          sc_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // m = sample-edge index + 2; window k of the DUT counts rises at m in [16k, 16k+15].
   function automatic logic ro_val(input int m);
      int k, p;
      if (m < 0) return 1'b0;
      k = m / WC;
      p = m % WC;
      if (k > 63) return 1'b0;
      if (mode[k]) return ((p % 4) == 1) || ((p % 4) == 2);
      return (p % 2) == 1;
   endfunction

   task automatic load_frame(input logic [7:0] d, input logic stop);
      logic [10:0] fb;
      fb = {stop, d, 1'b1};
      for (int i = 0; i < 64; i++) mode[i] = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (fb[i]) begin
            if (i % 2 == 0) {mode[3*i], mode[3*i+1], mode[3*i+2]} = 3'b110;
            else            {mode[3*i], mode[3*i+1], mode[3*i+2]} = 3'b011;
         end else begin
            if (i % 2 == 0) {mode[3*i], mode[3*i+1], mode[3*i+2]} = 3'b100;
            else            {mode[3*i], mode[3*i+1], mode[3*i+2]} = 3'b001;
         end
      end
   endtask

   task automatic observe(input int e);
      if (bus.bit_valid) begin
         if (nbit < 32) bits_seen[nbit] = bus.bit_data;
         nbit++;
      end
      if (bus.byte_valid) begin
         nbyte++;
         last_byte = bus.byte_data;
         if (!bus.bit_valid) nonco++;
      end
      if (bus.frame_err) begin
         nerr++;
         if (!bus.bit_valid) nonco++;
      end
      if ((e % WC) == WC - 1) sc_q.push_back(int'(bus.sample_count));
   endtask

   task automatic session(input int nwin);
      nbit = 0; nbyte = 0; nerr = 0; nonco = 0;
      bits_seen = '0; last_byte = '0;
      sc_q.delete();
      for (int j = -3; j < 0; j++) begin
         @(negedge clk);
         bus.enable = 1'b0;
         bus.ro_in  = ro_val(j + 2);
      end
      for (int n = 0; n < WC * nwin + 2; n++) begin
         @(negedge clk);
         if (n > 0) observe(n - 1);
         bus.enable = 1'b1;
         bus.ro_in  = ro_val(n + 2);
      end
   endtask

   function automatic int count_pulses();
      return int'(bus.bit_valid) + int'(bus.byte_valid) + int'(bus.frame_err);
   endfunction

   initial begin
      bus.enable = 1'b0;
      bus.ro_in  = 1'b0;
      bus.thresh = 8'd8;
      for (int i = 0; i < 64; i++) mode[i] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sample_count", 32'(bus.sample_count), 32'd0);
      check("rst_bit_valid",    32'(bus.bit_valid),    32'd0);
      check("rst_byte_data",    32'(bus.byte_data),    32'd0);
      check("rst_leds",         32'(bus.leds),         32'd0);
      reset_n = 1'b1;

      // Constant cold oscillator: every window 8 edges, every bit 0, nothing framed.
      session(12);
      nbad = 0;
      foreach (sc_q[i]) if (sc_q[i] != 8) nbad++;
      check("cold_windows",   32'(sc_q.size()), 32'd12);
      check("cold_count_bad", 32'(nbad),        32'd0);
      check("cold_nbit",      32'(nbit),        32'd4);
      check("cold_bits",      bits_seen,        32'd0);
      check("cold_nbyte",     32'(nbyte),       32'd0);

      // Good frame 0xA5 with cold stop bit.
      load_frame(8'hA5, 1'b0);
      session(33);
      check("a5_nbit",      32'(nbit),      32'd11);
      check("a5_bits",      bits_seen,      32'h14B);
      check("a5_nbyte",     32'(nbyte),     32'd1);
      check("a5_nerr",      32'(nerr),      32'd0);
      check("a5_coincide",  32'(nonco),     32'd0);
      check("a5_last_byte", 32'(last_byte), 32'hA5);
      check("a5_byte_data", 32'(bus.byte_data), 32'hA5);
      check("a5_leds",      32'(bus.leds),  32'h5);
      check("a5_nwin",      32'(sc_q.size()), 32'd33);
      if (sc_q.size() == 33) begin
         check("a5_sc_hot0",  32'(sc_q[0]), 32'd4);
         check("a5_sc_cold2", 32'(sc_q[2]), 32'd8);
         check("a5_sc_hot4",  32'(sc_q[4]), 32'd4);
      end

      // Frame with hot stop bit: error pulse, byte_data keeps 0xA5.
      load_frame(8'h5A, 1'b1);
      session(33);
      check("err_nerr",      32'(nerr),      32'd1);
      check("err_nbyte",     32'(nbyte),     32'd0);
      check("err_coincide",  32'(nonco),     32'd0);
      check("err_byte_keep", 32'(bus.byte_data), 32'hA5);
      check("err_nbit",      32'(nbit),      32'd11);

      // Reset after start + 4 data bits, then a full 0x3C frame.
      load_frame(8'h77, 1'b0);
      session(15);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_sample_count", 32'(bus.sample_count), 32'd0);
      check("mid_rst_byte_data",    32'(bus.byte_data),    32'd0);
      check("mid_rst_leds",         32'(bus.leds),         32'd0);
      check("mid_rst_pulses",       32'(count_pulses()),   32'd0);
      check("mid_rst_bit_data",     32'(bus.bit_data),     32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      npulse = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         npulse += count_pulses();
      end
      check("rst_release_pulses", 32'(npulse), 32'd0);
      load_frame(8'h3C, 1'b0);
      session(33);
      check("x3c_nbyte",     32'(nbyte),     32'd1);
      check("x3c_byte_data", 32'(bus.byte_data), 32'h3C);
      check("x3c_leds",      32'(bus.leds),  32'hC);

      // Enable dropped mid-frame for 10 cycles, then frame 0x81.
      load_frame(8'hF0, 1'b0);
      session(20);
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.enable = 1'b0;
         npulse += count_pulses();
      end
      check("dis_pulses",    32'(npulse),         32'd0);
      check("dis_state",     32'(dut.state_q),    32'(IDLE));
      check("dis_byte_hold", 32'(bus.byte_data),  32'h3C);
      load_frame(8'h81, 1'b0);
      session(33);
      check("x81_nbyte",     32'(nbyte),     32'd1);
      check("x81_nerr",      32'(nerr),      32'd0);
      check("x81_byte_data", 32'(bus.byte_data), 32'h81);
      check("x81_leds",      32'(bus.leds),  32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
